// File: rtl/pipeline_cpu_pkg.sv
// Shared constants and pipeline-register bundles for pipeline_cpu.
// Optional EX-stage operand forwarding is enabled by defining FORWARD_EN.
package pipeline_cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int MEM_AW = 8;

  localparam logic [XLEN-1:0] NOP = 32'h0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_LUI
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
  } if_id_t;

  typedef struct packed {
    alu_op_e           alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic [XLEN-1:0]   rs_val;
    logic [XLEN-1:0]   rt_val;
    logic [XLEN-1:0]   imm;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   store_data;
    logic [REG_AW-1:0] dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [REG_AW-1:0] dest;
    logic              reg_write;
  } mem_wb_t;

endpackage

// File: rtl/pipeline_cpu_gpr.sv
// 32x32 register file: two read ports, one write port, write-through.
// Storage is intentionally not reset so preloaded values survive reset.
module gpr
  import pipeline_cpu_pkg::*;
(
  input  logic              clock,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] gp_registers [0:31];

  always_ff @(posedge clock) begin
    if (we && waddr != '0) gp_registers[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == '0) ? '0 :
                  (we && waddr == raddr1) ? wdata :
                  gp_registers[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 :
                  (we && waddr == raddr2) ? wdata :
                  gp_registers[raddr2];

endmodule

// File: rtl/pipeline_cpu_mem.sv
// Word-indexed instruction and data memories, async read, no reset.
// The IM write port exists for loaders; the core ties it off.
module pipeline_cpu_im
  import pipeline_cpu_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [MEM_AW-1:0] addr,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] ins_memory [0:255];

  always_ff @(posedge clock) begin
    if (we) ins_memory[waddr] <= wdata;
  end

  assign rdata = ins_memory[addr];

endmodule

module pipeline_cpu_dm
  import pipeline_cpu_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] data_memory [0:255];

  always_ff @(posedge clock) begin
    if (we) data_memory[addr] <= wdata;
  end

  assign rdata = data_memory[addr];

endmodule

// File: rtl/pipeline_cpu.sv
// Five-stage in-order MIPS-subset core (IF/ID/EX/MEM/WB).
// Define FORWARD_EN for EX operand forwarding; otherwise ID stalls on RAW.
module pipeline_cpu
  import pipeline_cpu_pkg::*;
(
  input logic clock,
  input logic reset
);

  logic [XLEN-1:0] pc;
  if_id_t  if_id;
  id_ex_t  id_ex, id_ex_d;
  ex_mem_t ex_mem, ex_mem_d;
  mem_wb_t mem_wb, mem_wb_d;

  logic [XLEN-1:0] instr_f, rs_val, rt_val, dm_rdata;
  logic [XLEN-1:0] fwd_a, fwd_b, opb, alu_y;
  logic            stall, r_ok;

  logic [5:0]        op, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [15:0]       imm16;

  pipeline_cpu_im IM (
    .clock (clock),
    .we    (1'b0),
    .waddr ({MEM_AW{1'b0}}),
    .wdata (NOP),
    .addr  (pc[9:2]),
    .rdata (instr_f)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      if_id <= '{instr: NOP};
    end else if (!stall) begin
      pc    <= pc + 32'd4;
      if_id <= '{instr: instr_f};
    end
  end

  assign op    = if_id.instr[31:26];
  assign rs    = if_id.instr[25:21];
  assign rt    = if_id.instr[20:16];
  assign rd    = if_id.instr[15:11];
  assign funct = if_id.instr[5:0];
  assign imm16 = if_id.instr[15:0];
  assign r_ok  = (op == OP_RTYPE) &&
                 (funct inside {FN_ADD, FN_SUBU, FN_AND, FN_OR, FN_SLT});

  gpr GPR (
    .clock  (clock),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rs_val),
    .rdata2 (rt_val),
    .we     (mem_wb.reg_write),
    .waddr  (mem_wb.dest),
    .wdata  (mem_wb.result)
  );

  always_comb begin
    id_ex_d        = '0;
    id_ex_d.rs     = rs;
    id_ex_d.rt     = rt;
    id_ex_d.rs_val = rs_val;
    id_ex_d.rt_val = rt_val;
    unique case (1'b1)
      r_ok: begin
        id_ex_d.dest      = rd;
        id_ex_d.reg_write = 1'b1;
        unique case (funct)
          FN_SUBU: id_ex_d.alu_op = ALU_SUB;
          FN_AND:  id_ex_d.alu_op = ALU_AND;
          FN_OR:   id_ex_d.alu_op = ALU_OR;
          FN_SLT:  id_ex_d.alu_op = ALU_SLT;
          default: id_ex_d.alu_op = ALU_ADD;
        endcase
      end
      op == OP_ADDIU: begin
        id_ex_d.dest      = rt;
        id_ex_d.reg_write = 1'b1;
        id_ex_d.alu_src   = 1'b1;
        id_ex_d.imm       = {{16{imm16[15]}}, imm16};
      end
      op == OP_ORI: begin
        id_ex_d.alu_op    = ALU_OR;
        id_ex_d.dest      = rt;
        id_ex_d.reg_write = 1'b1;
        id_ex_d.alu_src   = 1'b1;
        id_ex_d.imm       = {16'h0, imm16};
      end
      op == OP_LUI: begin
        id_ex_d.alu_op    = ALU_LUI;
        id_ex_d.dest      = rt;
        id_ex_d.reg_write = 1'b1;
        id_ex_d.alu_src   = 1'b1;
        id_ex_d.imm       = {imm16, 16'h0};
      end
      op == OP_LW: begin
        id_ex_d.dest      = rt;
        id_ex_d.reg_write = 1'b1;
        id_ex_d.mem_read  = 1'b1;
        id_ex_d.alu_src   = 1'b1;
        id_ex_d.imm       = {{16{imm16[15]}}, imm16};
      end
      op == OP_SW: begin
        id_ex_d.mem_write = 1'b1;
        id_ex_d.alu_src   = 1'b1;
        id_ex_d.imm       = {{16{imm16[15]}}, imm16};
      end
      default: ;
    endcase
    // $0 is never a producer, so hazard and forwarding can ignore it
    if (id_ex_d.dest == '0) id_ex_d.reg_write = 1'b0;
  end

`ifdef FORWARD_EN
  assign stall = id_ex.mem_read && id_ex.reg_write &&
                 (id_ex.dest == rs || id_ex.dest == rt);
`else
  assign stall = (id_ex.reg_write &&
                  (id_ex.dest == rs || id_ex.dest == rt)) ||
                 (ex_mem.reg_write &&
                  (ex_mem.dest == rs || ex_mem.dest == rt));
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     id_ex <= '0;
    else if (stall) id_ex <= '0;
    else            id_ex <= id_ex_d;
  end

  always_comb begin
    fwd_a = id_ex.rs_val;
    fwd_b = id_ex.rt_val;
`ifdef FORWARD_EN
    if (ex_mem.reg_write && ex_mem.dest == id_ex.rs)
      fwd_a = ex_mem.alu_result;
    else if (mem_wb.reg_write && mem_wb.dest == id_ex.rs)
      fwd_a = mem_wb.result;
    if (ex_mem.reg_write && ex_mem.dest == id_ex.rt)
      fwd_b = ex_mem.alu_result;
    else if (mem_wb.reg_write && mem_wb.dest == id_ex.rt)
      fwd_b = mem_wb.result;
`endif
  end

  assign opb = id_ex.alu_src ? id_ex.imm : fwd_b;

  always_comb begin
    alu_y = '0;
    unique case (id_ex.alu_op)
      ALU_ADD: alu_y = fwd_a + opb;
      ALU_SUB: alu_y = fwd_a - opb;
      ALU_AND: alu_y = fwd_a & opb;
      ALU_OR:  alu_y = fwd_a | opb;
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(opb)};
      ALU_LUI: alu_y = opb;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.alu_result = alu_y;
    ex_mem_d.store_data = fwd_b;
    ex_mem_d.dest       = id_ex.dest;
    ex_mem_d.reg_write  = id_ex.reg_write;
    ex_mem_d.mem_read   = id_ex.mem_read;
    ex_mem_d.mem_write  = id_ex.mem_write;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ex_mem <= '0;
    else        ex_mem <= ex_mem_d;
  end

  pipeline_cpu_dm DM (
    .clock (clock),
    .we    (ex_mem.mem_write),
    .addr  (ex_mem.alu_result[9:2]),
    .wdata (ex_mem.store_data),
    .rdata (dm_rdata)
  );

  always_comb begin
    mem_wb_d           = '0;
    mem_wb_d.result    = ex_mem.mem_read ? dm_rdata : ex_mem.alu_result;
    mem_wb_d.dest      = ex_mem.dest;
    mem_wb_d.reg_write = ex_mem.reg_write;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mem_wb <= '0;
    else        mem_wb <= mem_wb_d;
  end

  logic unused_bits;
  assign unused_bits = ^{pc[31:10], pc[1:0], if_id.instr[10:6],
                         ex_mem.alu_result[31:10],
                         ex_mem.alu_result[1:0], id_ex.rs, id_ex.rt};

endmodule

// File: tb/tb_pipeline_cpu.sv
// Directed bench for pipeline_cpu: program tables, final-state checks,
// writeback-edge timing, load-use, $0, unknown opcode, mid-run reset.
module tb_pipeline_cpu;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    string       name;
    bit          is_dm;
    int          idx;
    logic [31:0] exp;
  } chk_t;

`ifdef FORWARD_EN
  localparam int LU_WB = 7;
`else
  localparam int LU_WB = 8;
`endif

  pipeline_cpu CPU (
    .clock (clock),
    .reset (reset)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs,
                                        logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] gpr(int i);
    return CPU.GPR.gp_registers[i];
  endfunction

  function automatic logic [31:0] dm(int i);
    return CPU.DM.data_memory[i];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [31:0] p[$]);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) begin
      CPU.IM.ins_memory[i]  = 32'h0;
      CPU.DM.data_memory[i] = 32'h0;
    end
    for (int i = 0; i < 32; i++) CPU.GPR.gp_registers[i] = 32'(i);
    foreach (p[i]) CPU.IM.ins_memory[i] = p[i];
  endtask

  task automatic release_rst();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    chk_t        tbl[$];
    logic [31:0] prog[$];

    reset = 1'b1;
    #2;

    tbl.push_back('{"add_r1",   0, 1,  32'h0000_0005});
    tbl.push_back('{"subu_r4",  0, 4,  32'hFFFF_FFFF});
    tbl.push_back('{"and_r7",   0, 7,  32'h0000_0008});
    tbl.push_back('{"addiu_r10",0, 10, 32'h0000_006F});
    tbl.push_back('{"ori_raw",  0, 12, 32'h0000_557F});
    tbl.push_back('{"lw_r15",   0, 15, 32'h0000_000E});
    tbl.push_back('{"slt_r16",  0, 16, 32'h0000_0001});
    tbl.push_back('{"lui_r19",  0, 19, 32'h0064_0000});
    tbl.push_back('{"or_r20",   0, 20, 32'h0000_0017});
    tbl.push_back('{"sw_dm2",   1, 2,  32'h0000_000E});
    tbl.push_back('{"keep_r0",  0, 0,  32'h0000_0000});
    tbl.push_back('{"keep_r2",  0, 2,  32'h0000_0002});
    tbl.push_back('{"keep_r11", 0, 11, 32'h0000_000B});
    tbl.push_back('{"keep_r14", 0, 14, 32'h0000_000E});
    tbl.push_back('{"keep_r21", 0, 21, 32'h0000_0015});
    tbl.push_back('{"keep_r31", 0, 31, 32'h0000_001F});
    tbl.push_back('{"keep_dm3", 1, 3,  32'h0000_0000});

    prog = '{enc_r(2, 3, 1, 6'h20),
             enc_r(5, 6, 4, 6'h23),
             enc_r(8, 9, 7, 6'h24),
             enc_i(6'h09, 11, 10, 16'd100),
             enc_i(6'h0D, 10, 12, 16'h5555),
             enc_i(6'h2B, 0, 14, 16'd8),
             enc_i(6'h23, 0, 15, 16'd8),
             enc_r(17, 18, 16, 6'h2A),
             enc_i(6'h0F, 0, 19, 16'd100),
             enc_r(21, 22, 20, 6'h25)};
    load(prog);
    check("pc_in_reset", CPU.pc, 32'h0);
    release_rst();
    step(1);
    check("pc_first_fetch", CPU.pc, 32'h4);
    step(3);
    check("r1_before_wb5", gpr(1), 32'h1);
    step(1);
    check("r1_at_wb5", gpr(1), 32'h5);
    step(40);
    for (int i = 0; i < tbl.size(); i++) begin
      check(tbl[i].name,
            tbl[i].is_dm ? dm(tbl[i].idx) : gpr(tbl[i].idx),
            tbl[i].exp);
    end

    prog = '{enc_i(6'h23, 0, 15, 16'd8),
             enc_r(15, 1, 21, 6'h20)};
    load(prog);
    CPU.DM.data_memory[2] = 32'hE;
    release_rst();
    step(LU_WB - 1);
    check("lu_r21_early", gpr(21), 32'h15);
    step(1);
    check("lu_r21_wb", gpr(21), 32'hF);
    step(10);
    check("lu_r15", gpr(15), 32'hE);

    prog = '{enc_r(2, 3, 0, 6'h20),
             enc_r(0, 1, 24, 6'h20)};
    load(prog);
    release_rst();
    step(15);
    check("r0_write_dropped", gpr(0), 32'h0);
    check("r0_reader", gpr(24), 32'h1);

    prog = '{32'hFC00_0000,
             enc_r(2, 3, 25, 6'h21),
             enc_i(6'h3F, 0, 1, 16'd0),
             enc_i(6'h09, 0, 26, 16'd5)};
    load(prog);
    CPU.DM.data_memory[0] = 32'hDEAD_BEEF;
    release_rst();
    step(15);
    check("unk_r25", gpr(25), 32'h19);
    check("unk_r1", gpr(1), 32'h1);
    check("unk_dm0", dm(0), 32'hDEAD_BEEF);
    check("unk_then_addiu", gpr(26), 32'h5);

    prog = '{enc_i(6'h09, 1, 1, 16'd1),
             enc_i(6'h09, 0, 2, 16'h77)};
    load(prog);
    release_rst();
    step(3);
    reset = 1'b0;
    #1;
    check("rst_pc", CPU.pc, 32'h0);
    step(3);
    check("rst_r1_no_commit", gpr(1), 32'h1);
    check("rst_r2_no_commit", gpr(2), 32'h2);
    check("rst_r5_kept", gpr(5), 32'h5);
    release_rst();
    step(12);
    check("rst_r1_once", gpr(1), 32'h2);
    check("rst_r2_restart", gpr(2), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
